// File: rtl/axil_pkg.sv
// Shared types for the AXI4-Lite to BRAM controller: response codes and FSM states.
package axil_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    SLVERR = 2'b10
  } resp_t;

  typedef enum logic [1:0] {
    IDLE,
    RD_DATA,
    WR_RESP
  } state_t;

endpackage

// File: rtl/axil_rw_arb.sv
// Two-requester fair arbiter: when both request, grant the side opposite the last grant.
module axil_rw_arb (
  input  logic clk,
  input  logic rst,
  input  logic i_en,
  input  logic i_rd_req,
  input  logic i_wr_req,
  output logic o_gnt_rd,
  output logic o_gnt_wr
);

  logic r_prio_rd;

  assign o_gnt_rd = i_en & i_rd_req & (~i_wr_req | r_prio_rd);
  assign o_gnt_wr = i_en & i_wr_req & (~i_rd_req | ~r_prio_rd);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_prio_rd <= 1'b1;
    end else if (o_gnt_rd) begin
      r_prio_rd <= 1'b0;
    end else if (o_gnt_wr) begin
      r_prio_rd <= 1'b1;
    end
  end

endmodule

// File: rtl/axil_bram_ctrl.sv
// AXI4-Lite slave driving one native BRAM port, one outstanding transaction.
// Define AXIL_BRAM_OOR_ERR_EN to answer out-of-range addresses with SLVERR instead of aliasing.
module axil_bram_ctrl
  import axil_pkg::*;
#(
  parameter int ADDR_WIDTH     = 10,
  parameter int DATA_WIDTH     = 32,
  parameter int AXI_ADDR_WIDTH = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [AXI_ADDR_WIDTH-1:0] s_awaddr,
  input  logic                      s_awvalid,
  output logic                      s_awready,
  input  logic [DATA_WIDTH-1:0]     s_wdata,
  input  logic [DATA_WIDTH/8-1:0]   s_wstrb,
  input  logic                      s_wvalid,
  output logic                      s_wready,
  output logic [1:0]                s_bresp,
  output logic                      s_bvalid,
  input  logic                      s_bready,
  input  logic [AXI_ADDR_WIDTH-1:0] s_araddr,
  input  logic                      s_arvalid,
  output logic                      s_arready,
  output logic [DATA_WIDTH-1:0]     s_rdata,
  output logic [1:0]                s_rresp,
  output logic                      s_rvalid,
  input  logic                      s_rready,
  output logic                      bram_en,
  output logic                      bram_we,
  output logic [DATA_WIDTH/8-1:0]   bram_wstrb,
  output logic [ADDR_WIDTH-1:0]     bram_addr,
  output logic [DATA_WIDTH-1:0]     bram_din,
  input  logic [DATA_WIDTH-1:0]     bram_dout
);

  state_t                r_state;
  logic                  r_bvalid;
  logic                  r_rvalid;
  logic                  r_rd_first;
  resp_t                 r_bresp;
  resp_t                 r_rresp;
  logic [DATA_WIDTH-1:0] r_rdata;

  logic w_idle;
  logic w_gnt_rd;
  logic w_gnt_wr;
  logic w_wr_oor;
  logic w_rd_oor;
  logic w_wr_bram;
  logic w_rd_bram;
  logic w_unused;

  assign w_idle = (r_state == IDLE);

`ifdef AXIL_BRAM_OOR_ERR_EN
  assign w_wr_oor = (s_awaddr >> (ADDR_WIDTH + 2)) != '0;
  assign w_rd_oor = (s_araddr >> (ADDR_WIDTH + 2)) != '0;
`else
  assign w_wr_oor = 1'b0;
  assign w_rd_oor = 1'b0;
`endif
  assign w_unused = ^{s_awaddr, s_araddr};

  axil_rw_arb u_arb (
    .clk      (clk),
    .rst      (rst),
    .i_en     (w_idle),
    .i_rd_req (s_arvalid),
    .i_wr_req (s_awvalid & s_wvalid),
    .o_gnt_rd (w_gnt_rd),
    .o_gnt_wr (w_gnt_wr)
  );

  assign s_awready = w_gnt_wr;
  assign s_wready  = w_gnt_wr;
  assign s_arready = w_gnt_rd;

  assign w_wr_bram  = w_gnt_wr & ~w_wr_oor;
  assign w_rd_bram  = w_gnt_rd & ~w_rd_oor;
  assign bram_en    = w_wr_bram | w_rd_bram;
  assign bram_we    = w_wr_bram;
  assign bram_wstrb = w_wr_bram ? s_wstrb : '0;
  assign bram_addr  = w_gnt_wr ? s_awaddr[ADDR_WIDTH+1:2] : s_araddr[ADDR_WIDTH+1:2];
  assign bram_din   = s_wdata;

  assign s_bvalid = r_bvalid;
  assign s_bresp  = r_bresp;
  assign s_rvalid = r_rvalid;
  assign s_rresp  = r_rresp;
  // First RD_DATA cycle forwards the BRAM output register; later cycles hold the captured copy.
  assign s_rdata  = r_rd_first ? bram_dout : r_rdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_bvalid   <= 1'b0;
      r_rvalid   <= 1'b0;
      r_rd_first <= 1'b0;
      r_bresp    <= OKAY;
      r_rresp    <= OKAY;
      r_rdata    <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_gnt_wr) begin
            r_state  <= WR_RESP;
            r_bvalid <= 1'b1;
            r_bresp  <= w_wr_oor ? SLVERR : OKAY;
          end else if (w_gnt_rd) begin
            r_state    <= RD_DATA;
            r_rvalid   <= 1'b1;
            r_rresp    <= w_rd_oor ? SLVERR : OKAY;
            r_rd_first <= ~w_rd_oor;
            r_rdata    <= '0;
          end
        end
        RD_DATA: begin
          r_rd_first <= 1'b0;
          if (r_rd_first) begin
            r_rdata <= bram_dout;
          end
          if (s_rready) begin
            r_rvalid <= 1'b0;
            r_state  <= IDLE;
          end
        end
        WR_RESP: begin
          if (s_bready) begin
            r_bvalid <= 1'b0;
            r_state  <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axil_bram_ctrl.sv
// Randomized bench for axil_bram_ctrl with a transaction-level memory model and per-cycle compare.
module tb_axil_bram_ctrl;

  localparam int AW = 10;
  localparam int DW = 32;
  localparam int XW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [XW-1:0] s_awaddr = '0;
  logic          s_awvalid = 1'b0;
  logic          s_awready;
  logic [DW-1:0] s_wdata = '0;
  logic [3:0]    s_wstrb = '0;
  logic          s_wvalid = 1'b0;
  logic          s_wready;
  logic [1:0]    s_bresp;
  logic          s_bvalid;
  logic          s_bready = 1'b0;
  logic [XW-1:0] s_araddr = '0;
  logic          s_arvalid = 1'b0;
  logic          s_arready;
  logic [DW-1:0] s_rdata;
  logic [1:0]    s_rresp;
  logic          s_rvalid;
  logic          s_rready = 1'b0;
  logic          bram_en;
  logic          bram_we;
  logic [3:0]    bram_wstrb;
  logic [AW-1:0] bram_addr;
  logic [DW-1:0] bram_din;
  logic [DW-1:0] bram_dout = '0;

  int n_vec = 0;
  int n_err = 0;

  axil_bram_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .AXI_ADDR_WIDTH(XW)) dut (
    .clk(clk), .rst(rst),
    .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
    .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
    .bram_en(bram_en), .bram_we(bram_we), .bram_wstrb(bram_wstrb),
    .bram_addr(bram_addr), .bram_din(bram_din), .bram_dout(bram_dout)
  );

  always #5 clk = ~clk;

  // Environment BRAM: one-cycle registered read, byte-enabled write.
  logic [DW-1:0] bram_mem [0:(1<<AW)-1];
  initial for (int i = 0; i < (1<<AW); i++) bram_mem[i] = '0;
  always @(posedge clk) begin
    if (bram_en) begin
      if (bram_we) begin
        for (int b = 0; b < 4; b++)
          if (bram_wstrb[b]) bram_mem[bram_addr][8*b +: 8] <= bram_din[8*b +: 8];
      end else begin
        bram_dout <= bram_mem[bram_addr];
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic timeout(input string nm);
    n_vec++;
    n_err++;
    $display("FAIL %s: no handshake within bound, got 0 expected 1", nm);
  endtask

  function automatic bit is_oor(input logic [XW-1:0] a);
`ifdef AXIL_BRAM_OOR_ERR_EN
    return (a >> (AW + 2)) != 0;
`else
    return 1'b0;
`endif
  endfunction

  // Reference model: memory image, outstanding-response record, last grant side.
  logic [DW-1:0] ref_mem [0:(1<<AW)-1];
  initial for (int i = 0; i < (1<<AW); i++) ref_mem[i] = '0;
  bit            m_busy = 0;
  bit            m_rd = 0;
  bit            m_last_rd = 0;
  logic [DW-1:0] m_exp_data;
  logic [1:0]    m_exp_resp;
  byte           grant_log[$];

  always @(negedge clk) begin
    bit wr_p, rd_p, g_w, g_r, ow, orr;
    int idx;
    if (rst) begin
      m_busy = 0;
      m_last_rd = 0;
    end else begin
      wr_p = s_awvalid && s_wvalid;
      rd_p = s_arvalid;
      g_w = !m_busy && wr_p && (!rd_p || m_last_rd);
      g_r = !m_busy && rd_p && (!wr_p || !m_last_rd);
      ow = is_oor(s_awaddr);
      orr = is_oor(s_araddr);
      chk("arready", s_arready, g_r);
      chk("awready", s_awready, g_w);
      chk("wready", s_wready, g_w);
      chk("bram_en", bram_en, (g_w && !ow) || (g_r && !orr));
      chk("bram_we", bram_we, g_w && !ow);
      chk("bram_wstrb", bram_wstrb, (g_w && !ow) ? s_wstrb : 4'h0);
      if (g_w && !ow) begin
        chk("bram_addr_wr", bram_addr, s_awaddr[AW+1:2]);
        chk("bram_din", bram_din, s_wdata);
      end
      if (g_r && !orr) chk("bram_addr_rd", bram_addr, s_araddr[AW+1:2]);
      chk("bvalid", s_bvalid, m_busy && !m_rd);
      chk("rvalid", s_rvalid, m_busy && m_rd);
      if (m_busy && m_rd) begin
        chk("rdata", s_rdata, m_exp_data);
        chk("rresp", s_rresp, m_exp_resp);
      end
      if (m_busy && !m_rd) chk("bresp", s_bresp, m_exp_resp);
      if (m_busy && ((m_rd && s_rready) || (!m_rd && s_bready))) m_busy = 0;
      if (g_w) begin
        idx = int'(s_awaddr % (1 << (AW + 2))) / 4;
        if (!ow)
          for (int b = 0; b < 4; b++)
            if (s_wstrb[b]) ref_mem[idx][8*b +: 8] = s_wdata[8*b +: 8];
        m_busy = 1; m_rd = 0; m_last_rd = 0;
        m_exp_resp = ow ? 2'b10 : 2'b00;
        grant_log.push_back("W");
      end
      if (g_r) begin
        idx = int'(s_araddr % (1 << (AW + 2))) / 4;
        m_busy = 1; m_rd = 1; m_last_rd = 1;
        m_exp_data = orr ? '0 : ref_mem[idx];
        m_exp_resp = orr ? 2'b10 : 2'b00;
        grant_log.push_back("R");
      end
    end
  end

  // gap > 0: AW leads W by gap cycles; gap < 0: W leads AW.
  task automatic wr_txn(input logic [XW-1:0] addr, input logic [DW-1:0] data,
                        input logic [3:0] strb, input int gap, input int bdly,
                        output logic [1:0] resp);
    int cnt, ag;
    bit done;
    ag = (gap < 0) ? -gap : gap;
    s_awaddr = addr; s_wdata = data; s_wstrb = strb;
    if (gap > 0) s_awvalid = 1'b1;
    else if (gap < 0) s_wvalid = 1'b1;
    else begin s_awvalid = 1'b1; s_wvalid = 1'b1; end
    cnt = 0; done = 0; resp = 2'bxx;
    while (!done) begin
      @(negedge clk);
      done = s_awready && s_wready && s_awvalid && s_wvalid;
      @(posedge clk); #1;
      cnt++;
      if (cnt == ag) begin s_awvalid = 1'b1; s_wvalid = 1'b1; end
      if (!done && cnt > 200) begin timeout("aw_w_accept"); break; end
    end
    s_awvalid = 1'b0; s_wvalid = 1'b0;
    cnt = 0; done = 0; s_bready = (bdly == 0);
    while (!done) begin
      @(negedge clk);
      if (s_bvalid && s_bready) begin done = 1; resp = s_bresp; end
      @(posedge clk); #1;
      cnt++;
      if (cnt >= bdly) s_bready = 1'b1;
      if (!done && cnt > 200) begin timeout("bvalid"); break; end
    end
    s_bready = 1'b0;
  endtask

  task automatic rd_txn(input logic [XW-1:0] addr, input int rdly,
                        output logic [DW-1:0] data, output logic [1:0] resp);
    int cnt;
    bit done;
    s_araddr = addr; s_arvalid = 1'b1;
    cnt = 0; done = 0; data = 'x; resp = 2'bxx;
    while (!done) begin
      @(negedge clk);
      done = s_arready;
      @(posedge clk); #1;
      cnt++;
      if (!done && cnt > 200) begin timeout("ar_accept"); break; end
    end
    s_arvalid = 1'b0;
    cnt = 0; done = 0; s_rready = (rdly == 0);
    while (!done) begin
      @(negedge clk);
      if (s_rvalid && s_rready) begin done = 1; data = s_rdata; resp = s_rresp; end
      @(posedge clk); #1;
      cnt++;
      if (cnt >= rdly) s_rready = 1'b1;
      if (!done && cnt > 200) begin timeout("rvalid"); break; end
    end
    s_rready = 1'b0;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
  endtask

  function automatic logic [XW-1:0] rand_addr();
    logic [XW-1:0] hi;
    hi = ($urandom_range(0, 7) == 0) ? XW'($urandom_range(1, 3)) : '0;
    return (hi << (AW + 2)) | XW'($urandom_range(0, 15) << 2) | XW'($urandom_range(0, 3));
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] d;
    logic [1:0]    r;
    logic [XW-1:0] base;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_arready", s_arready, 0);
    chk("rst_awready", s_awready, 0);
    chk("rst_bvalid", s_bvalid, 0);
    chk("rst_rvalid", s_rvalid, 0);
    chk("rst_rdata", s_rdata, 0);
    chk("rst_bresp", s_bresp, 0);
    chk("rst_rresp", s_rresp, 0);
    chk("rst_bram_en", bram_en, 0);
    @(posedge clk); #1;

    wr_txn(32'h10, 32'hDEADBEEF, 4'hF, 0, 0, r);
    chk("t1_bresp", r, 2'b00);
    rd_txn(32'h10, 0, d, r);
    chk("t1_rdata", d, 32'hDEADBEEF);
    chk("t1_rresp", r, 2'b00);

    wr_txn(32'h13, 32'h000000AA, 4'h1, 0, 0, r);
    rd_txn(32'h10, 0, d, r);
    chk("t2_rdata", d, 32'hDEADBEAA);

    wr_txn(32'h14, 32'h0BADF00D, 4'h0, 0, 5, r);
    chk("zero_strb_bresp", r, 2'b00);
    rd_txn(32'h14, 5, d, r);
    chk("zero_strb_rdata", d, 32'h0);

    wr_txn(32'h20, 32'h11223344, 4'hF, 4, 0, r);
    wr_txn(32'h24, 32'h55667788, 4'hC, -3, 2, r);
    rd_txn(32'h24, 1, d, r);
    chk("w_lead_rdata", d, 32'h55660000);

    wr_txn(32'h0, 32'h12345678, 4'hF, 0, 0, r);
    rd_txn(32'h1 << (AW + 2), 0, d, r);
`ifdef AXIL_BRAM_OOR_ERR_EN
    chk("oor_rresp", r, 2'b10);
    chk("oor_rdata", d, 32'h0);
`else
    chk("alias_rresp", r, 2'b00);
    chk("alias_rdata", d, 32'h12345678);
`endif

    pulse_reset();
    grant_log.delete();
    fork
      begin
        logic [DW-1:0] dd; logic [1:0] rr;
        repeat (2) rd_txn(32'h10, 0, dd, rr);
      end
      begin
        logic [1:0] rr;
        wr_txn(32'h30, 32'hA5A5A5A5, 4'hF, 0, 0, rr);
        wr_txn(32'h34, 32'h5A5A5A5A, 4'hF, 0, 0, rr);
      end
    join
    chk("grant_count", grant_log.size(), 4);
    if (grant_log.size() >= 4) begin
      chk("grant0", grant_log[0], "R");
      chk("grant1", grant_log[1], "W");
      chk("grant2", grant_log[2], "R");
      chk("grant3", grant_log[3], "W");
    end

    base = '0;
    fork
      begin
        logic [DW-1:0] dd; logic [1:0] rr;
        repeat (150) begin
          repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
          rd_txn(rand_addr(), $urandom_range(0, 4), dd, rr);
        end
      end
      begin
        logic [1:0] rr;
        repeat (150) begin
          repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
          wr_txn(rand_addr() | base, $urandom(), 4'($urandom_range(0, 15)),
                 $urandom_range(0, 6) - 3, $urandom_range(0, 4), rr);
        end
      end
    join

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
